// File: rtl/ram256x8_pkg.sv
// Shared constants and types for the 256x8 RAM arbiter / zero-fill sequencer.
package ram256x8_pkg;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    // Last word written by the zero-fill sweep.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Conflict resolution modes.
    localparam int PRIO_RR    = 0;  // loser of the previous conflict wins
    localparam int PRIO_FIXED = 1;  // port 0 always wins a conflict

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/ram256x8_arb_if.sv
// Requester, zero-fill and RAM-side signals of the arbiter as one bundle.
interface ram256x8_arb_if;
    import ram256x8_pkg::*;

    logic          REQ0, WR0, ACK0;
    logic [AW-1:0] A0;
    logic [DW-1:0] D0, Q0;
    logic          REQ1, WR1, ACK1;
    logic [AW-1:0] A1;
    logic [DW-1:0] D1, Q1;
    logic          CLR, BUSY;
    logic [AW-1:0] RA;
    logic [DW-1:0] RD, RO;
    logic          RWE;

    // Arbiter side.
    modport slave (
        input  REQ0, WR0, A0, D0, REQ1, WR1, A1, D1, CLR, RO,
        output ACK0, Q0, ACK1, Q1, BUSY, RA, RD, RWE
    );

    // Requesters plus the RAM instance.
    modport master (
        output REQ0, WR0, A0, D0, REQ1, WR1, A1, D1, CLR, RO,
        input  ACK0, Q0, ACK1, Q1, BUSY, RA, RD, RWE
    );

endinterface

// File: rtl/ram256x8_arb_arb2_rr.sv
// Two-input arbiter: masks the port granted last edge, resolves conflicts
// by round-robin pointer or fixed port-0 priority, emits a one-hot grant.
module arb2_rr
    import ram256x8_pkg::*;
#(
    parameter int PRIO = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt
);

    logic       ptr;   // 0: port 0 wins the next conflict
    logic [1:0] elig;
    logic       conflict;

    // A port granted last edge still has its ACK in flight, so it sits out.
    assign elig     = en ? (req & ~last) : 2'b00;
    assign conflict = &elig;

    // Grant selection.
    always_comb begin
        gnt = elig;
        if (conflict)
            gnt = (PRIO == PRIO_FIXED || !ptr) ? 2'b01 : 2'b10;
    end

    // Pointer moves to the loser, and only on a real conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (conflict && PRIO == PRIO_RR)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/ram256x8_arb.sv
// Shares a 256x8 async-read / sync-write RAM between two requesters and a
// zero-fill engine. RAM port is registered; read data and ACK return one
// cycle after the access cycle.
module ram256x8_arb
    import ram256x8_pkg::*;
#(
    parameter int PRIO = PRIO_RR
) (
    input logic           CLK,
    input logic           RSTN,
    ram256x8_arb_if.slave bus
);

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [AW-1:0] ra_q, ra_nx;
    logic [DW-1:0] rd_q, rd_nx;
    logic          rwe_q, rwe_nx;
    logic [DW-1:0] q0_q, q1_q;
    logic [1:0]    gnt, gnt_q, ack_q;
    logic          fill_ld, fill_done;

    // The sweep ends once address 255 has been presented to the RAM.
    assign fill_done = (state == FILL) && (ra_q == LAST_ADDR);
    // CLR beats a same-edge request; requests resume on the exit edge.
    assign fill_ld   = (state == IDLE) ? bus.CLR : !fill_done;

    arb2_rr #(.PRIO(PRIO)) u_arb (
        .clk   (CLK),
        .rst_n (RSTN),
        .en    (!fill_ld),
        .req   ({bus.REQ1, bus.REQ0}),
        .last  (gnt_q),
        .gnt   (gnt)
    );

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.CLR)   state_nx = FILL;
            FILL:    if (fill_done) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Next RAM-port values: fill word, granted operands, or hold with RWE low.
    always_comb begin
        ra_nx  = ra_q;
        rd_nx  = rd_q;
        rwe_nx = 1'b0;
        cnt_nx = cnt;
        if (fill_ld) begin
            ra_nx  = cnt;
            rd_nx  = '0;
            rwe_nx = 1'b1;
            cnt_nx = cnt + AW'(1);  // wraps to 0 after the last word
        end else if (gnt[0]) begin
            ra_nx  = bus.A0;
            rd_nx  = bus.D0;
            rwe_nx = bus.WR0;
        end else if (gnt[1]) begin
            ra_nx  = bus.A1;
            rd_nx  = bus.D1;
            rwe_nx = bus.WR1;
        end
    end

    // RAM-port, grant-id pipeline and return-path registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt   <= '0;
            ra_q  <= '0;
            rd_q  <= '0;
            rwe_q <= 1'b0;
            gnt_q <= 2'b00;
            ack_q <= 2'b00;
            q0_q  <= '0;
            q1_q  <= '0;
        end else begin
            cnt   <= cnt_nx;
            ra_q  <= ra_nx;
            rd_q  <= rd_nx;
            rwe_q <= rwe_nx;
            gnt_q <= gnt;
            ack_q <= gnt_q;
            // RWE here is still the flag of the access being completed.
            if (gnt_q[0] && !rwe_q) q0_q <= bus.RO;
            if (gnt_q[1] && !rwe_q) q1_q <= bus.RO;
        end
    end

    assign bus.RA   = ra_q;
    assign bus.RD   = rd_q;
    assign bus.RWE  = rwe_q;
    assign bus.ACK0 = ack_q[0];
    assign bus.ACK1 = ack_q[1];
    assign bus.Q0   = q0_q;
    assign bus.Q1   = q1_q;
    assign bus.BUSY = (state == FILL);

endmodule

// File: tb/tb_ram256x8_arb.sv
// Directed bench for ram256x8_arb: RAM models, read-data scoreboard,
// round-robin and fixed-priority instances.
module tb_ram256x8_arb;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ram256x8_arb_if bus0 ();
    ram256x8_arb_if bus1 ();

    ram256x8_arb #(.PRIO(0)) u_dut0 (.CLK(clk), .RSTN(rstn), .bus(bus0));
    ram256x8_arb #(.PRIO(1)) u_dut1 (.CLK(clk), .RSTN(rstn), .bus(bus1));

    // RAM models (async read, sync write); mem0 has a bench preload port.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       pl_we = 1'b0;
    logic [7:0] pl_a = '0, pl_d = '0;

    always @(posedge clk) begin
        if (pl_we)         mem0[pl_a] <= pl_d;
        else if (bus0.RWE) mem0[bus0.RA] <= bus0.RD;
    end
    always @(posedge clk) if (bus1.RWE) mem1[bus1.RA] <= bus1.RD;
    assign bus0.RO = mem0[bus0.RA];
    assign bus1.RO = mem1[bus1.RA];

    int checks = 0;
    int failures = 0;
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    function automatic logic [7:0] pop0();
        logic [7:0] e;
        e = 'x;
        if (sb0.size() > 0) e = sb0.pop_front();
        return e;
    endfunction

    function automatic logic [7:0] pop1();
        logic [7:0] e;
        e = 'x;
        if (sb1.size() > 0) e = sb1.pop_front();
        return e;
    endfunction

    // One access on dut0 port p; call at a negedge.
    task automatic do_access(input int p, input bit wr, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] exp_q, input int exp_lat, input string tag);
        int lat;
        bit seen;
        lat = 0; seen = 1'b0;
        if (p == 0) begin
            bus0.REQ0 = 1'b1; bus0.WR0 = wr; bus0.A0 = a; bus0.D0 = d;
            if (!wr) sb0.push_back(exp_q);
        end else begin
            bus0.REQ1 = 1'b1; bus0.WR1 = wr; bus0.A1 = a; bus0.D1 = d;
            if (!wr) sb1.push_back(exp_q);
        end
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = (p == 0) ? bus0.ACK0 : bus0.ACK1;
        end
        chk({tag, "_ack"}, 32'(seen), 32'd1);
        if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!wr) begin
            if (p == 0) chk({tag, "_q"}, 32'(bus0.Q0), 32'(pop0()));
            else        chk({tag, "_q"}, 32'(bus0.Q1), 32'(pop1()));
        end
        if (p == 0) bus0.REQ0 = 1'b0;
        else        bus0.REQ1 = 1'b0;
    endtask

    // Both ports of dut d request at once; check which address reaches RA first.
    task automatic conflict(input int d, input logic [7:0] first, input logic [7:0] second,
                            input string tag);
        if (d == 0) begin
            bus0.REQ0 = 1; bus0.WR0 = 0; bus0.A0 = 8'h10;
            bus0.REQ1 = 1; bus0.WR1 = 0; bus0.A1 = 8'h20;
        end else begin
            bus1.REQ0 = 1; bus1.WR0 = 0; bus1.A0 = 8'h10;
            bus1.REQ1 = 1; bus1.WR1 = 0; bus1.A1 = 8'h20;
        end
        @(negedge clk);
        chk({tag, "_first"}, 32'((d == 0) ? bus0.RA : bus1.RA), 32'(first));
        @(negedge clk);
        chk({tag, "_second"}, 32'((d == 0) ? bus0.RA : bus1.RA), 32'(second));
        bus0.REQ0 = 0; bus0.REQ1 = 0; bus1.REQ0 = 0; bus1.REQ1 = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus0.REQ0 = 0; bus0.WR0 = 0; bus0.A0 = 0; bus0.D0 = 0;
        bus0.REQ1 = 0; bus0.WR1 = 0; bus0.A1 = 0; bus0.D1 = 0; bus0.CLR = 0;
        bus1.REQ0 = 0; bus1.WR0 = 0; bus1.A0 = 0; bus1.D0 = 0;
        bus1.REQ1 = 0; bus1.WR1 = 0; bus1.A1 = 0; bus1.D1 = 0; bus1.CLR = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(bus0.ACK0), 0);
        chk("rst_ack1", 32'(bus0.ACK1), 0);
        chk("rst_q0",   32'(bus0.Q0), 0);
        chk("rst_q1",   32'(bus0.Q1), 0);
        chk("rst_busy", 32'(bus0.BUSY), 0);
        chk("rst_ra",   32'(bus0.RA), 0);
        chk("rst_rd",   32'(bus0.RD), 0);
        chk("rst_rwe",  32'(bus0.RWE), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Port 0 write 0x3C=0xA5, then read back
        bus0.REQ0 = 1; bus0.WR0 = 1; bus0.A0 = 8'h3C; bus0.D0 = 8'hA5;
        @(negedge clk);
        chk("t1_wr_port", 32'({bus0.RWE, bus0.RA, bus0.RD}), 32'h13CA5);
        chk("t1_wr_noack", 32'(bus0.ACK0), 0);
        @(negedge clk);
        chk("t1_wr_ack", 32'(bus0.ACK0), 1);
        chk("t1_rwe_pulse", 32'(bus0.RWE), 0);
        bus0.REQ0 = 0;
        @(negedge clk);
        chk("t1_ack_one_cycle", 32'(bus0.ACK0), 0);
        do_access(0, 0, 8'h3C, 8'h00, 8'hA5, 2, "t1_rd");
        @(negedge clk);

        // Both ports held, PRIO=0: strict alternation
        preload(8'h10, 8'h5A);
        preload(8'h20, 8'hC3);
        repeat (4) sb0.push_back(8'h5A);
        repeat (4) sb1.push_back(8'hC3);
        bus0.REQ0 = 1; bus0.WR0 = 0; bus0.A0 = 8'h10;
        bus0.REQ1 = 1; bus0.WR1 = 0; bus0.A1 = 8'h20;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("t2_no_double_ack", 32'(bus0.ACK0 & bus0.ACK1), 0);
            chk("t2_ack0", 32'(bus0.ACK0), 32'((k % 2 == 0) && k <= 8));
            chk("t2_ack1", 32'(bus0.ACK1), 32'((k % 2 == 1) && k >= 3 && k <= 9));
            if (bus0.ACK0) chk("t2_q0", 32'(bus0.Q0), 32'(pop0()));
            if (bus0.ACK1) chk("t2_q1", 32'(bus0.Q1), 32'(pop1()));
            if (k == 8) begin bus0.REQ0 = 0; bus0.REQ1 = 0; end
        end
        chk("t2_sb0_empty", 32'(sb0.size()), 0);
        chk("t2_sb1_empty", 32'(sb1.size()), 0);

        // Conflict pointer (dut0 lost by port 1 last time) and fixed priority (dut1)
        conflict(0, 8'h20, 8'h10, "t3_rr");
        conflict(1, 8'h10, 8'h20, "t3_prio_a");
        conflict(1, 8'h10, 8'h20, "t3_prio_b");

        // Zero-fill over 0xFF with port 1 holding a read of 0x80
        for (int i = 0; i < 256; i++) preload(8'(i), 8'hFF);
        bus0.CLR = 1;
        bus0.REQ1 = 1; bus0.WR1 = 0; bus0.A1 = 8'h80;
        sb1.push_back(8'h00);
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            bus0.CLR = 0;
            chk("t4_fill", 32'({bus0.BUSY, bus0.RWE, bus0.RD, bus0.RA, bus0.ACK1}),
                32'({1'b1, 1'b1, 8'h00, 8'(k - 1), 1'b0}));
        end
        @(negedge clk);
        chk("t4_busy_fall", 32'(bus0.BUSY), 0);
        chk("t4_grant", 32'({bus0.RWE, bus0.RA}), 32'h080);
        @(negedge clk);
        chk("t4_ack1", 32'(bus0.ACK1), 1);
        chk("t4_q1", 32'(bus0.Q1), 32'(pop1()));
        bus0.REQ1 = 0;
        @(negedge clk);

        // CLR and a port-0 write at the same edge
        bus0.CLR = 1;
        bus0.REQ0 = 1; bus0.WR0 = 1; bus0.A0 = 8'h05; bus0.D0 = 8'h77;
        @(negedge clk);
        bus0.CLR = 0;
        chk("t5_fill_first", 32'({bus0.BUSY, bus0.RWE, bus0.RA}), 32'h300);
        for (int k = 2; k <= 256; k++) begin
            @(negedge clk);
            chk("t5_wait", 32'({bus0.BUSY, bus0.ACK0}), 32'h2);
        end
        @(negedge clk);
        chk("t5_grant", 32'({bus0.BUSY, bus0.RWE, bus0.RA, bus0.RD}), 32'h10577);
        @(negedge clk);
        chk("t5_ack0", 32'(bus0.ACK0), 1);
        bus0.REQ0 = 0;
        @(negedge clk);
        do_access(1, 0, 8'h05, 8'h00, 8'h77, 2, "t5_rd");
        @(negedge clk);

        // Reset with an ACK pending in IDLE
        bus0.REQ0 = 1; bus0.WR0 = 0; bus0.A0 = 8'h05;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6a_rst", 32'({bus0.ACK0, bus0.RWE, bus0.RA, bus0.Q1}), 0);
        bus0.REQ0 = 0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t6a_no_ack", 32'(bus0.ACK0), 0);
        @(negedge clk);

        // Reset during FILL at address 100 with port 1 waiting
        bus0.CLR = 1;
        bus0.REQ1 = 1; bus0.WR1 = 0; bus0.A1 = 8'h07;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            bus0.CLR = 0;
        end
        chk("t6_at100", 32'({bus0.BUSY, bus0.RA}), 32'h164);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({bus0.ACK0, bus0.ACK1, bus0.BUSY, bus0.RWE}), 0);
        chk("t6_rst_bus", 32'({bus0.Q0, bus0.Q1, bus0.RA, bus0.RD}), 0);
        bus0.REQ1 = 0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_ack", 32'({bus0.ACK0, bus0.ACK1, bus0.BUSY}), 0);
        end
        do_access(0, 1, 8'h07, 8'h3E, 8'h00, 2, "t6_wr");
        @(negedge clk);
        do_access(1, 0, 8'h07, 8'h00, 8'h3E, 2, "t6_rd");
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
